// File: rtl/conv3x3_pe_array_if.sv
// Bus bundle for conv3x3_pe_array: configuration, window/weight input stream,
// result stream and status. The slave modport is the PE array; master drives it.
interface conv3x3_pe_array_if #(
  parameter int DW    = 8,
  parameter int LANES = 4,
  parameter int ACCW  = 24,
  parameter int CINW  = 8
);
  logic                      cfg_start;
  logic [CINW-1:0]           cfg_cin;
  logic [4:0]                cfg_shift;
  logic                      cfg_relu;
  logic [LANES*ACCW-1:0]     cfg_bias;

  // Handshakes: a beat moves on a rising edge where valid && ready are both
  // high; the sender keeps data and valid stable until that edge.
  logic                      win_valid;
  logic                      win_ready;
  logic [9*DW-1:0]           win_data;
  logic [LANES*9*DW-1:0]     wt_data;

  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DW-1:0]       out_data;

  logic                      busy;
  logic                      done;
  logic [1:0]                dbg_state;

  modport slave (
    input  cfg_start, cfg_cin, cfg_shift, cfg_relu, cfg_bias,
    input  win_valid, win_data, wt_data, out_ready,
    output win_ready, out_valid, out_data, busy, done, dbg_state
  );

  modport master (
    output cfg_start, cfg_cin, cfg_shift, cfg_relu, cfg_bias,
    output win_valid, win_data, wt_data, out_ready,
    input  win_ready, out_valid, out_data, busy, done, dbg_state
  );
endinterface

// File: rtl/conv3x3_pe_array.sv
// 3x3 convolution PE array: LANES output channels accumulate one input channel
// per beat through a 3-stage multiply/sum/accumulate pipeline, then requantise.
module conv3x3_pe_array #(
  parameter int DW    = 8,
  parameter int LANES = 4,
  parameter int ACCW  = 24,
  parameter int CINW  = 8
) (
  input  logic                clk,
  input  logic                rst,
  conv3x3_pe_array_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_DRAIN  = 2'd2,
    S_OUTPUT = 2'd3
  } state_e;

  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = -SAT_MAX - ACCW'(1);

  state_e state_q, state_d;

  logic signed [2*DW-1:0] prod_d [LANES][9];
  logic signed [2*DW-1:0] prod_q [LANES][9];
  logic signed [ACCW-1:0] sum_d  [LANES];
  logic signed [ACCW-1:0] sum_q  [LANES];
  logic signed [ACCW-1:0] acc_q  [LANES];
  logic                   s1_valid_q, s2_valid_q;

  logic [CINW-1:0]        cin_q, cnt_q;
  logic [4:0]             shift_q;
  logic                   relu_q;
  logic [1:0]             drain_q;
  logic [LANES*DW-1:0]    res_d, out_data_q;
  logic                   done_q;

  logic start_ok, zero_start, beat, last_beat, fire, drain_end;

  assign start_ok   = bus.cfg_start && (state_q == S_IDLE) && (bus.cfg_cin != '0);
  assign zero_start = bus.cfg_start && (state_q == S_IDLE) && (bus.cfg_cin == '0);
  assign beat       = bus.win_valid && (state_q == S_ACCUM);
  assign last_beat  = beat && (cnt_q == cin_q - 1'b1);
  assign fire       = (state_q == S_OUTPUT) && bus.out_ready;
  assign drain_end  = (state_q == S_DRAIN) && (drain_q == 2'd2);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_ok)       state_d = S_ACCUM;
      S_ACCUM:  if (last_beat)      state_d = S_DRAIN;
      S_DRAIN:  if (drain_end)      state_d = S_OUTPUT;
      S_OUTPUT: if (bus.out_ready)  state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      for (int t = 0; t < 9; t++) begin
        prod_d[l][t] = $signed(bus.win_data[t*DW +: DW]) *
                       $signed(bus.wt_data[(l*9+t)*DW +: DW]);
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      sum_d[l] = '0;
      for (int t = 0; t < 9; t++) begin
        sum_d[l] = sum_d[l] + ACCW'(prod_q[l][t]);
      end
    end
  end

  // Round half up, shift arithmetically, optional ReLU, then clamp to DW bits.
  always_comb begin
    logic signed [ACCW-1:0] rnd, rounded, shifted;
    res_d   = '0;
    rounded = '0;
    shifted = '0;
    rnd     = (shift_q == 5'd0) ? '0 : (ACCW'(1) << (shift_q - 5'd1));
    for (int l = 0; l < LANES; l++) begin
      rounded = acc_q[l] + rnd;
      shifted = rounded >>> shift_q;
      if (relu_q && (shifted < 0)) shifted = '0;
      if (shifted > SAT_MAX)      shifted = SAT_MAX;
      else if (shifted < SAT_MIN) shifted = SAT_MIN;
      res_d[l*DW +: DW] = shifted[DW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      cin_q      <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      drain_q    <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        sum_q[l] <= '0;
        acc_q[l] <= '0;
        for (int t = 0; t < 9; t++) prod_q[l][t] <= '0;
      end
    end else begin
      state_q    <= state_d;
      s1_valid_q <= beat;
      s2_valid_q <= s1_valid_q;
      done_q     <= fire || zero_start;
      drain_q    <= (state_q == S_DRAIN) ? drain_q + 2'd1 : 2'd0;

      if (start_ok) begin
        cin_q   <= bus.cfg_cin;
        shift_q <= bus.cfg_shift;
        relu_q  <= bus.cfg_relu;
        cnt_q   <= '0;
      end else if (beat) begin
        cnt_q <= cnt_q + 1'b1;
      end

      for (int l = 0; l < LANES; l++) begin
        if (beat) begin
          for (int t = 0; t < 9; t++) prod_q[l][t] <= prod_d[l][t];
        end
        if (s1_valid_q) sum_q[l] <= sum_d[l];
        if (start_ok)        acc_q[l] <= bus.cfg_bias[l*ACCW +: ACCW];
        else if (s2_valid_q) acc_q[l] <= acc_q[l] + sum_q[l];
      end

      if (drain_end) out_data_q <= res_d;
    end
  end

  assign bus.win_ready = (state_q == S_ACCUM);
  assign bus.out_valid = (state_q == S_OUTPUT);
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_conv3x3_pe_array.sv
// Directed bench for conv3x3_pe_array with a queue-based result scoreboard.
module tb_conv3x3_pe_array;
  localparam int DW    = 8;
  localparam int LANES = 4;
  localparam int ACCW  = 24;
  localparam int CINW  = 8;
  localparam int OW    = LANES * DW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv3x3_pe_array_if #(.DW(DW), .LANES(LANES), .ACCW(ACCW), .CINW(CINW)) bus ();

  conv3x3_pe_array #(.DW(DW), .LANES(LANES), .ACCW(ACCW), .CINW(CINW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [OW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted result is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected: got %0h expected none", bus.out_data);
      end else begin
        check("out_data", bus.out_data, exp_q.pop_front());
      end
    end
  end

  function automatic logic [OW-1:0] rep_out(input logic [DW-1:0] v);
    logic [OW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [9*DW-1:0] rep_win(input logic [DW-1:0] v);
    logic [9*DW-1:0] r;
    for (int t = 0; t < 9; t++) r[t*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [LANES*9*DW-1:0] rep_wt(input logic [DW-1:0] v);
    logic [LANES*9*DW-1:0] r;
    for (int i = 0; i < LANES*9; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [LANES*ACCW-1:0] rep_bias(input logic [ACCW-1:0] v);
    logic [LANES*ACCW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*ACCW +: ACCW] = v;
    return r;
  endfunction

  task automatic start_pixel(input int cin, input int sh, input logic relu,
                             input logic [LANES*ACCW-1:0] bias);
    bus.cfg_cin   = CINW'(cin);
    bus.cfg_shift = 5'(sh);
    bus.cfg_relu  = relu;
    bus.cfg_bias  = bias;
    bus.cfg_start = 1'b1;
    @(posedge clk); #1;
    bus.cfg_start = 1'b0;
  endtask

  task automatic send_beat(input logic [9*DW-1:0] win, input logic [LANES*9*DW-1:0] wt,
                           input int gap);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    bus.win_data  = win;
    bus.wt_data   = wt;
    bus.win_valid = 1'b1;
    n = 0;
    while (!bus.win_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("win_ready_timeout", 64'(n < 50), 64'd1);
    @(posedge clk); #1;
    bus.win_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 100) begin @(posedge clk); #1; n++; end
    check("idle_timeout", 64'(n < 100), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [9*DW-1:0]       ramp_win;
    logic [LANES*9*DW-1:0] ramp_wt;
    logic [LANES*ACCW-1:0] bias_v;
    int seen;

    bus.cfg_start = 1'b0;
    bus.cfg_cin   = '0;
    bus.cfg_shift = '0;
    bus.cfg_relu  = 1'b0;
    bus.cfg_bias  = '0;
    bus.win_valid = 1'b0;
    bus.win_data  = '0;
    bus.wt_data   = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_win_ready", 64'(bus.win_ready), 64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);
    check("rst_done",      64'(bus.done),      64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_state",     64'(bus.dbg_state), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single channel, latency and back-pressure hold.
    bus.out_ready = 1'b0;
    start_pixel(1, 0, 1'b0, '0);
    exp_q.push_back(rep_out(8'd18));
    send_beat(rep_win(8'd1), rep_wt(8'd2), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("lat_not_yet", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_valid", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_data",  64'(bus.out_data),  64'(rep_out(8'd18)));
      check("hold_busy",  64'(bus.busy),      64'd1);
    end
    check("hold_no_done", 64'(bus.done), 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("accept_done",  64'(bus.done),      64'd1);
    check("accept_busy",  64'(bus.busy),      64'd0);
    check("accept_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check("done_pulse", 64'(bus.done), 64'd0);

    // Positive saturation, three channels with input gaps.
    start_pixel(3, 4, 1'b0, '0);
    exp_q.push_back(rep_out(8'd127));
    send_beat(rep_win(8'd100), rep_wt(8'd100), 0);
    send_beat(rep_win(8'd100), rep_wt(8'd100), 2);
    send_beat(rep_win(8'd100), rep_wt(8'd100), 1);
    wait_idle();

    // Negative saturation.
    start_pixel(3, 4, 1'b0, '0);
    exp_q.push_back(rep_out(8'h80));
    for (int b = 0; b < 3; b++) send_beat(rep_win(8'd100), rep_wt(8'h9C), b);
    wait_idle();

    // ReLU on and off with negative bias.
    start_pixel(1, 0, 1'b1, rep_bias(ACCW'(-50)));
    exp_q.push_back(rep_out(8'd0));
    send_beat(rep_win(8'd1), rep_wt(8'd1), 0);
    wait_idle();
    start_pixel(1, 0, 1'b0, rep_bias(ACCW'(-50)));
    exp_q.push_back(rep_out(8'hD7));
    send_beat(rep_win(8'd1), rep_wt(8'd1), 0);
    wait_idle();

    // Distinct per-lane weights, rounding shift and per-lane bias.
    for (int t = 0; t < 9; t++) ramp_win[t*DW +: DW] = DW'(t);
    for (int l = 0; l < LANES; l++)
      for (int t = 0; t < 9; t++) ramp_wt[(l*9+t)*DW +: DW] = DW'(l + 1);
    bias_v = '0;
    bias_v[0 +: ACCW] = ACCW'(3);
    start_pixel(2, 1, 1'b0, bias_v);
    exp_q.push_back({8'd127, 8'd108, 8'd72, 8'd38});
    send_beat(ramp_win, ramp_wt, 0);
    send_beat(ramp_win, ramp_wt, 3);
    wait_idle();

    // Zero input channels.
    start_pixel(0, 0, 1'b0, '0);
    check("zero_done", 64'(bus.done), 64'd1);
    check("zero_busy", 64'(bus.busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.busy || bus.done) seen++;
    end
    check("zero_quiet", 64'(seen), 64'd0);

    // cfg_start while accumulating must be ignored.
    start_pixel(2, 0, 1'b0, '0);
    exp_q.push_back(rep_out(8'd36));
    send_beat(rep_win(8'd1), rep_wt(8'd2), 0);
    bus.cfg_cin   = CINW'(1);
    bus.cfg_shift = 5'd3;
    bus.cfg_relu  = 1'b1;
    bus.cfg_bias  = rep_bias(ACCW'(100));
    bus.cfg_start = 1'b1;
    @(posedge clk); #1;
    bus.cfg_start = 1'b0;
    check("ignore_state", 64'(bus.dbg_state), 64'd1);
    send_beat(rep_win(8'd1), rep_wt(8'd2), 1);
    wait_idle();

    // Reset while draining aborts the pixel.
    start_pixel(1, 0, 1'b0, '0);
    send_beat(rep_win(8'd5), rep_wt(8'd5), 0);
    @(posedge clk); #1;
    check("drain_state", 64'(bus.dbg_state), 64'd2);
    rst = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_win_ready", 64'(bus.win_ready), 64'd0);
    check("arst_busy",      64'(bus.busy),      64'd0);
    check("arst_done",      64'(bus.done),      64'd0);
    check("arst_out_data",  64'(bus.out_data),  64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.done || bus.busy) seen++;
    end
    check("arst_quiet", 64'(seen), 64'd0);

    start_pixel(1, 0, 1'b0, '0);
    exp_q.push_back(rep_out(8'd18));
    send_beat(rep_win(8'd1), rep_wt(8'd2), 0);
    wait_idle();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
